// File: rtl/main_decoder.sv
// LEGv8 main control decoder: combinational opcode decode, registered controls (1-cycle latency).
// Optional MAINDEC_ILLEGAL_EN adds a registered 'illegal' flag for unmatched opcodes.
module main_decoder #(
  parameter int OP_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [OP_W-1:0] Op,
  output logic            valid,
  output logic            Reg2Loc,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
`ifdef MAINDEC_ILLEGAL_EN
  output logic            illegal,
`endif
  output logic [1:0]      ALUOp
);

  localparam logic [10:0] OP_LDUR    = 11'b11111000010;
  localparam logic [10:0] OP_STUR    = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [10:0] OP_ADD     = 11'b10001011000;
  localparam logic [10:0] OP_SUB     = 11'b11001011000;
  localparam logic [10:0] OP_AND     = 11'b10001010000;
  localparam logic [10:0] OP_ORR     = 11'b10101010000;

  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  hit;
  logic  valid_q;
  logic  illegal_q;

  // NOTE: defaults first so every path assigns every bit and no latch is inferred.
  always_comb begin
    ctrl_d = '0;
    hit    = 1'b1;
    if (Op == OP_LDUR) begin
      ctrl_d = '{reg2loc: 1'b0, alusrc: 1'b1, memtoreg: 1'b1, regwrite: 1'b1,
                 memread: 1'b1, memwrite: 1'b0, branch: 1'b0, aluop: 2'b00};
    end else if (Op == OP_STUR) begin
      ctrl_d = '{reg2loc: 1'b1, alusrc: 1'b1, memtoreg: 1'b0, regwrite: 1'b0,
                 memread: 1'b0, memwrite: 1'b1, branch: 1'b0, aluop: 2'b00};
    end else if (Op[10:3] == OP_CBZ_PFX) begin
      ctrl_d = '{reg2loc: 1'b1, alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b0,
                 memread: 1'b0, memwrite: 1'b0, branch: 1'b1, aluop: 2'b01};
    end else if (Op == OP_ADD || Op == OP_SUB || Op == OP_AND || Op == OP_ORR) begin
      ctrl_d = '{reg2loc: 1'b0, alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b1,
                 memread: 1'b0, memwrite: 1'b0, branch: 1'b0, aluop: 2'b10};
    end else begin
      hit = 1'b0;
    end
  end

  // A bubble (op_valid = 0) loads all-zero controls regardless of Op.
  // NOTE: non-blocking assignments in clocked logic avoid simulation ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= op_valid;
      ctrl_q    <= op_valid ? ctrl_d : '0;
      illegal_q <= op_valid & ~hit;
    end
  end

  assign valid    = valid_q;
  assign Reg2Loc  = ctrl_q.reg2loc;
  assign ALUSrc   = ctrl_q.alusrc;
  assign MemtoReg = ctrl_q.memtoreg;
  assign RegWrite = ctrl_q.regwrite;
  assign MemRead  = ctrl_q.memread;
  assign MemWrite = ctrl_q.memwrite;
  assign Branch   = ctrl_q.branch;
  assign ALUOp    = ctrl_q.aluop;

`ifdef MAINDEC_ILLEGAL_EN
  assign illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_main_decoder.sv
// Scoreboard bench for main_decoder: stimulus pushes expected controls, a monitor pops and compares.
// Build with +define+MAINDEC_ILLEGAL_EN to also check the illegal flag.
module tb_main_decoder;

  typedef struct packed {
    logic       v;
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       ill;
  } exp_t;

  //                         v  r2l src m2r rw  mr  mw  br  aluop  ill
  localparam exp_t E_ZERO = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0};
  localparam exp_t E_LDUR = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0};
  localparam exp_t E_STUR = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0};
  localparam exp_t E_CBZ  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0};
  localparam exp_t E_RTYP = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,1'b0};
`ifdef MAINDEC_ILLEGAL_EN
  localparam exp_t E_UNK  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1};
`else
  localparam exp_t E_UNK  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0};
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [10:0] Op;
  logic        valid, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [1:0]  ALUOp;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  main_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .Op       (Op),
    .valid    (valid),
    .Reg2Loc  (Reg2Loc),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
`ifdef MAINDEC_ILLEGAL_EN
    .illegal  (illegal),
`endif
    .ALUOp    (ALUOp)
  );

`ifndef MAINDEC_ILLEGAL_EN
  assign illegal = 1'b0;
`endif

  function automatic exp_t actual();
    return '{valid, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, illegal};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got v/r2l/src/m2r/rw/mr/mw/br/aluop/ill=%b, want %b", name, act, exp);
    end
  endtask

  // Drive one decode slot on the falling edge and queue what the next rising edge must produce.
  task automatic issue(input logic ov, input logic [10:0] op, input exp_t exp);
    @(negedge clk);
    op_valid = ov;
    Op       = op;
    sb.push_back(exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("decode", actual(), e);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset    = 1'b1;
    op_valid = 1'b0;
    Op       = '0;
    #2;
    check("reset_state", actual(), E_ZERO);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Load a non-zero decode, then assert reset mid-cycle and expect an immediate clear.
    issue(1'b1, 11'b11111000010, E_LDUR);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_clear", actual(), E_ZERO);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    check("held_in_reset", actual(), E_ZERO);
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(E_ZERO);

    issue(1'b1, 11'b11111000010, E_LDUR);
    issue(1'b1, 11'b11111000000, E_STUR);
    issue(1'b1, 11'b10110100010, E_CBZ);
    issue(1'b1, 11'b10110100111, E_CBZ);
    issue(1'b1, 11'b10001011000, E_RTYP);
    issue(1'b1, 11'b11001011000, E_RTYP);
    issue(1'b1, 11'b10001010000, E_RTYP);
    issue(1'b1, 11'b10101010000, E_RTYP);
    issue(1'b1, 11'b11111111111, E_UNK);
    issue(1'b1, 11'b00000000000, E_UNK);
    issue(1'b1, 11'b11111000001, E_UNK);
    issue(1'b1, 11'b10110101000, E_UNK);
    issue(1'b1, 11'b10001011001, E_UNK);
    issue(1'b0, 11'b11111000010, E_ZERO);
    issue(1'b1, 11'b11111000000, E_STUR);
    issue(1'b0, 11'b10001011000, E_ZERO);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- Main control decoder for the LEGv8 pipeline/CPU datapath.
- Takes the 11-bit instruction opcode field (instr[31:21]) and produces the datapath control bits for LDUR, STUR, CBZ and the R-type ADD/SUB/AND/ORR.
- Decode is combinational. The control outputs are registered, giving 1-cycle latency, so the block sits at the decode-stage boundary.

Parameters:
- OP_W, 11, opcode field width. Fixed at 11; other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  Op carries a valid instruction this cycle.
- Op  input  11  instruction opcode bits [31:21].
- valid  output  1  registered copy of op_valid.
- Reg2Loc  output  1  1 selects Rt (instr[4:0]) as register-read address 2; 0 selects Rm.
- ALUSrc  output  1  1 selects the sign-extended immediate as ALU operand B.
- MemtoReg  output  1  1 selects data-memory read data for write-back.
- RegWrite  output  1  register-file write enable.
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- Branch  output  1  conditional-branch (CBZ) indicator.
- ALUOp  output  2  00 = add (address), 01 = pass/compare-zero, 10 = R-type (funct decode in ALU control).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset asserted: all outputs go to 0 immediately, including valid and ALUOp = 00. Outputs hold 0 until the first rising clk edge after reset deasserts.
- Latency: outputs reflect the Op/op_valid sampled at the previous rising edge. No handshake or back-pressure; a new decode is taken every cycle.
- op_valid = 0 at an edge: valid = 0 and all control outputs load 0 (bubble/NOP). Op is ignored.
- op_valid = 1: the registers load the decode below, and valid = 1.
- Decode table, listed as Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp:
  - LDUR, Op = 11111000010: 0 1 1 1 1 0 0 00
  - STUR, Op = 11111000000: 1 1 0 0 0 1 0 00
  - CBZ, Op[10:3] = 10110100 (Op[2:0] don't-care): 1 0 0 0 0 0 1 01
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: 0 0 0 1 0 0 0 10
  - Any other opcode, including all-ones and all-zeros: all 0, ALUOp = 00. Never write register or memory.
- LDUR, STUR and the R-types require an exact 11-bit match. Only CBZ uses a prefix match.
- Don't-care fields in the textbook table are fixed at the values above. Outputs never carry X for any defined input.
- Reset mid-stream: the in-flight decode is discarded and outputs clear asynchronously.

Optional Feature:
- Macro MAINDEC_ILLEGAL_EN.
- Defined: adds output port illegal (1 bit, registered, reset 0). illegal = 1 when op_valid = 1 and Op matches no table entry; control outputs are still all 0.
- Undefined: the port does not exist and unknown opcodes simply decode to all-zero controls.

Test Plan:
- Reset asserted mid-cycle with outputs non-zero -> all outputs 0 without waiting for clk; they remain 0 for one edge after release with op_valid = 0.
- op_valid = 1, Op = 11111000010 (LDUR) then 11111000000 (STUR) -> one cycle later 0 1 1 1 1 0 0 00, then 1 1 0 0 0 1 0 00, with valid = 1 each cycle.
- Op = 10110100010 and 10110100111 (CBZ) -> 1 0 0 0 0 0 1 01 for both.
- Op = 10001011000, 11001011000, 10001010000, 10101010000 back-to-back -> 0 0 0 1 0 0 0 10 each cycle, valid held 1.
- Op = 11111111111, 00000000000, 11111000001 -> all controls 0, ALUOp = 00, valid = 1; illegal = 1 when MAINDEC_ILLEGAL_EN is defined.
- op_valid = 0 with Op = 11111000010 -> valid = 0, all controls 0 next cycle.
